// File: rtl/rfg_pkg.sv
// Shared address map, data width and decode helpers for the rfg register bank.
package rfg_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [7:0] FIFO_DATA_ADDR_DEFAULT      = 8'hF0;
   localparam logic [7:0] FIFO_LEVEL_ADDR_DEFAULT     = 8'hF1;
   localparam logic [7:0] FIFO_UNDERFLOW_ADDR_DEFAULT = 8'hF2;

   function automatic logic is_reg_addr(input logic [7:0] addr, input int unsigned num_regs);
      return ({24'h000000, addr} < num_regs);
   endfunction

   // Level is reported through a byte-wide register, so deep FIFOs clip at 255.
   function automatic logic [7:0] sat_level(input logic [8:0] level);
      return (level > 9'd255) ? 8'hFF : level[7:0];
   endfunction

endpackage

// File: rtl/rfg_register_bank_fifo.sv
// Synchronous byte FIFO with push, pop, flush and an occupancy count.
// Head data is combinational so the caller can register it on the pop edge.
module rfg_register_bank_fifo
   import rfg_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [BYTE_W-1:0] head_data,
   output logic [LW-1:0]     level,
   output logic              full,
   output logic              empty
);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW-1:0]     rd_ptr_d;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              do_push;
   logic              do_pop;

   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == {LW{1'b0}});
   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

   // Pointer and level next-state; a flush overrides any push or pop that cycle.
   always_comb begin
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = {LW{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
         endcase
      end
   end

   // Storage array, left unreset so it can map onto distributed RAM.
   always_ff @(posedge aclk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointer and level registers.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/rfg_register_bank.sv
// Register-file target for the AXIS register protocol engine: byte config
// registers plus a readout FIFO drained through fixed data/level/underflow addresses.
module rfg_register_bank
   import rfg_pkg::*;
#(
   parameter int unsigned NUM_REGS            = 16,
   parameter logic [7:0]  REG_RESET_VALUE     = 8'h00,
   parameter int unsigned FIFO_DEPTH          = 32,
   parameter logic [7:0]  FIFO_DATA_ADDR      = FIFO_DATA_ADDR_DEFAULT,
   parameter logic [7:0]  FIFO_LEVEL_ADDR     = FIFO_LEVEL_ADDR_DEFAULT,
   parameter logic [7:0]  FIFO_UNDERFLOW_ADDR = FIFO_UNDERFLOW_ADDR_DEFAULT
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [7:0]            rfg_address,
   input  logic [7:0]            rfg_write_value,
   input  logic                  rfg_write,
   input  logic                  rfg_write_last,
   input  logic                  rfg_read,
   output logic                  rfg_read_valid,
   output logic [7:0]            rfg_read_value,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [NUM_REGS*8-1:0] regs_out,
   output logic [NUM_REGS-1:0]   reg_write_strobe,
   output logic                  cfg_update
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] reg_write_strobe_q;
   logic [NUM_REGS-1:0] reg_write_strobe_d;
   logic                cfg_update_q;
   logic                cfg_update_d;
   logic                read_valid_q;
   logic                read_valid_d;
   logic [7:0]          read_value_q;
   logic [7:0]          read_value_d;
   logic [7:0]          underflow_q;
   logic [7:0]          underflow_d;
   logic                rst_done_q;
   logic                rst_done_d;

   logic                addr_is_reg;
   logic                wr_reg;
   logic [7:0]          reg_read_value;
   logic [7:0]          read_mux;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_flush;
   logic [7:0]          fifo_head;
   logic [LW-1:0]       fifo_level;
   logic                fifo_full;
   logic                fifo_empty;

   rfg_register_bank_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (fifo_push),
      .push_data (s_axis_tdata),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head_data (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // tready is held low until the first clock after reset releases.
   assign s_axis_tready    = rst_done_q && !fifo_full;
   assign rfg_read_valid   = read_valid_q;
   assign rfg_read_value   = read_value_q;
   assign reg_write_strobe = reg_write_strobe_q;
   assign cfg_update       = cfg_update_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[8*g +: 8] = regs_q[g];
   end

   // Address decode, register next-state and FIFO control strobes.
   always_comb begin
      addr_is_reg    = is_reg_addr(rfg_address, NUM_REGS);
      wr_reg         = rfg_write && addr_is_reg;
      fifo_flush     = rfg_write && (rfg_address == FIFO_DATA_ADDR);
      fifo_pop       = rfg_read && (rfg_address == FIFO_DATA_ADDR);
      fifo_push      = s_axis_tvalid && s_axis_tready;
      cfg_update_d   = rfg_write && rfg_write_last;
      rst_done_d     = 1'b1;
      reg_read_value = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i]             = (wr_reg && (rfg_address == 8'(i))) ? rfg_write_value : regs_q[i];
         reg_write_strobe_d[i] = wr_reg && (rfg_address == 8'(i));
         reg_read_value        = reg_read_value | ((rfg_address == 8'(i)) ? regs_q[i] : 8'h00);
      end
   end

   // Underflow counter: cleared by a write, saturating increment on an empty pop.
   always_comb begin
      underflow_d = underflow_q;
      if (rfg_write && (rfg_address == FIFO_UNDERFLOW_ADDR)) begin
         underflow_d = 8'h00;
      end else if (fifo_pop && fifo_empty && (underflow_q != 8'hFF)) begin
         underflow_d = underflow_q + 8'h01;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // Read mux; its result is captured one cycle after the read strobe.
   always_comb begin
      read_mux = 8'h00;
      if (addr_is_reg) begin
         read_mux = reg_read_value;
      end else begin
         case (rfg_address)
            FIFO_DATA_ADDR:      read_mux = fifo_empty ? 8'h00 : fifo_head;
            FIFO_LEVEL_ADDR:     read_mux = sat_level(9'(fifo_level));
            FIFO_UNDERFLOW_ADDR: read_mux = underflow_q;
            default:             read_mux = 8'h00;
         endcase
      end
      read_valid_d = rfg_read;
      if (rfg_read) begin
         read_value_d = read_mux;
      end else begin
         read_value_d = 8'h00;
      end
   end

   // Config register array.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= REG_RESET_VALUE;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Output pulses, read response, underflow count and reset-done flag.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         reg_write_strobe_q <= {NUM_REGS{1'b0}};
         cfg_update_q       <= 1'b0;
         read_valid_q       <= 1'b0;
         read_value_q       <= 8'h00;
         underflow_q        <= 8'h00;
         rst_done_q         <= 1'b0;
      end else begin
         reg_write_strobe_q <= reg_write_strobe_d;
         cfg_update_q       <= cfg_update_d;
         read_valid_q       <= read_valid_d;
         read_value_q       <= read_value_d;
         underflow_q        <= underflow_d;
         rst_done_q         <= rst_done_d;
      end
   end

endmodule
